// File: rtl/ysyx_040729_axi_pkg.sv
// Shared AXI constants, refill FSM state encoding and beat-size helper for axi_line_fill.
package ysyx_040729_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    RESP = 2'd3
  } fill_state_e;

  function automatic int beat_bytes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/axi_line_fill_if.sv
// Bundle of the cache refill port and the AXI AR/R channels seen by axi_line_fill.
// master = the bridge itself; slave = cache requester plus AXI memory side.
interface axi_line_fill_if #(
  parameter int LINE_WIDTH     = 256,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4
);
  logic [AXI_ADDR_WIDTH-1:0] r_addr_i;
  logic [2:0]                r_size_i;
  logic                      r_valid_i;
  logic                      r_ready_o;
  logic [LINE_WIDTH-1:0]     r_data_o;
  logic                      r_err_o;

  logic [AXI_ADDR_WIDTH-1:0] araddr;
  logic [7:0]                arlen;
  logic [2:0]                arsize;
  logic [1:0]                arburst;
  logic [AXI_ID_WIDTH-1:0]   arid;
  logic                      arvalid;
  logic                      arready;

  logic                      rvalid;
  logic                      rready;
  logic [AXI_DATA_WIDTH-1:0] rdata;
  logic [1:0]                rresp;
  logic                      rlast;
  logic [AXI_ID_WIDTH-1:0]   rid;

  modport master (
    input  r_addr_i, r_size_i, r_valid_i,
    output r_ready_o, r_data_o, r_err_o,
    output araddr, arlen, arsize, arburst, arid, arvalid,
    input  arready,
    input  rvalid, rdata, rresp, rlast, rid,
    output rready
  );

  modport slave (
    output r_addr_i, r_size_i, r_valid_i,
    input  r_ready_o, r_data_o, r_err_o,
    input  araddr, arlen, arsize, arburst, arid, arvalid,
    output arready,
    output rvalid, rdata, rresp, rlast, rid,
    input  rready
  );
endinterface

// File: rtl/axi_line_fill.sv
// Turns one I-cache refill request into one AXI4 INCR read burst and returns the assembled line.
// Define AXI_LINE_FILL_FAST_RESP_EN to return the line combinationally on the rlast beat.
module axi_line_fill
  import ysyx_040729_axi_pkg::*;
#(
  parameter int LINE_WIDTH     = 256,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4
) (
  input logic clock,
  input logic reset,
  axi_line_fill_if.master bus
);

  localparam int LANES      = LINE_WIDTH / AXI_DATA_WIDTH;
  localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int SIZE_LSB   = $clog2(beat_bytes(AXI_DATA_WIDTH));
  localparam logic [7:0] MAX_LEN = 8'(LANES - 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_AR   = AR;
  localparam logic [1:0] ST_R    = R;
  localparam logic [1:0] ST_RESP = RESP;
`ifdef AXI_LINE_FILL_FAST_RESP_EN
  localparam logic [1:0] ST_AFTER_LAST = ST_IDLE;
`else
  localparam logic [1:0] ST_AFTER_LAST = ST_RESP;
`endif

  logic [1:0]                state_q;
  logic [7:0]                cnt_q;
  logic                      err_q;
  logic [AXI_ADDR_WIDTH-1:0] araddr_q;
  logic [7:0]                arlen_q;
  logic [AXI_DATA_WIDTH-1:0] line_q [LANES];

  logic [AXI_ADDR_WIDTH-1:0] req_addr;
  logic [7:0]                req_len;
  logic [2:0]                clr_bits;
  logic                      capture;
  logic                      beat;
  logic                      in_range;
  logic                      beat_err;
  logic [LANE_W-1:0]         lane;
  logic [LINE_WIDTH-1:0]     line_packed;
  logic                      rid_unused;

  assign rid_unused = ^bus.rid;

  // Request decode: beats = 2^size / beat_bytes, at least one, capped at a full line.
  always_comb begin
    clr_bits = (bus.r_size_i > 3'(SIZE_LSB)) ? bus.r_size_i : 3'(SIZE_LSB);
    req_addr = bus.r_addr_i & ({AXI_ADDR_WIDTH{1'b1}} << clr_bits);
    if (bus.r_size_i <= 3'(SIZE_LSB)) begin
      req_len = '0;
    end else if ((bus.r_size_i - 3'(SIZE_LSB)) >= 3'(LANE_W)) begin
      req_len = MAX_LEN;
    end else begin
      req_len = 8'((1 << (bus.r_size_i - 3'(SIZE_LSB))) - 1);
    end
  end

  assign capture  = (state_q == ST_IDLE) && bus.r_valid_i;
  assign beat     = (state_q == ST_R) && bus.rvalid;
  assign in_range = cnt_q < 8'(LANES);
  assign lane     = cnt_q[LANE_W-1:0];
  // cnt+1 != arlen+1 reduces to cnt != arlen for the rlast length check.
  assign beat_err = (bus.rresp != AXI_RESP_OKAY) || !in_range ||
                    (bus.rlast && (cnt_q != arlen_q));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.r_valid_i) begin
            cnt_q   <= '0;
            err_q   <= 1'b0;
            state_q <= ST_AR;
          end
        end
        ST_AR: begin
          if (bus.arready) state_q <= ST_R;
        end
        ST_R: begin
          if (beat) begin
            if (cnt_q != '1) cnt_q <= cnt_q + 8'd1;
            if (beat_err) err_q <= 1'b1;
            if (bus.rlast) state_q <= ST_AFTER_LAST;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // AR fields are captured once and held for the whole AR phase.
  always_ff @(posedge clock) begin
    if (capture) begin
      araddr_q <= req_addr;
      arlen_q  <= req_len;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < LANES; k++) line_q[k] <= '0;
    end else if (capture) begin
      for (int k = 0; k < LANES; k++) line_q[k] <= '0;
    end else if (beat && in_range) begin
      line_q[lane] <= bus.rdata;
    end
  end

  always_comb begin
    line_packed = '0;
    for (int k = 0; k < LANES; k++) begin
      line_packed[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = line_q[k];
    end
  end

  assign bus.arvalid = (state_q == ST_AR);
  assign bus.rready  = (state_q == ST_R);
  assign bus.araddr  = araddr_q;
  assign bus.arlen   = arlen_q;
  assign bus.arsize  = 3'(SIZE_LSB);
  assign bus.arburst = AXI_BURST_INCR;
  assign bus.arid    = '0;

`ifdef AXI_LINE_FILL_FAST_RESP_EN
  logic last_beat;
  assign last_beat = beat && bus.rlast;

  always_comb begin
    bus.r_data_o = line_packed;
    if (last_beat && in_range) begin
      bus.r_data_o[lane*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = bus.rdata;
    end
  end

  assign bus.r_ready_o = last_beat;
  assign bus.r_err_o   = last_beat && (err_q || beat_err);
`else
  assign bus.r_data_o  = line_packed;
  assign bus.r_ready_o = (state_q == ST_RESP);
  assign bus.r_err_o   = (state_q == ST_RESP) && err_q;
`endif

endmodule
